// File: rtl/ysyx_24110015_mem_arbiter.sv
// 2:1 round-robin arbiter sharing one memory port between icache refill (IF) and the LSU (LS).
// Grants lock until mem_ready; also keeps a contention counter and a sticky stuck-grant watchdog.
module ysyx_24110015_mem_arbiter #(
    parameter int TIMEOUT   = 1024,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic [31:0]          if_addr,
    input  logic                 if_valid,
    output logic [31:0]          if_rdata,
    output logic                 if_ready,

    input  logic [31:0]          ls_addr,
    input  logic                 ls_valid,
    input  logic                 ls_wen,
    input  logic [31:0]          ls_wdata,
    input  logic [3:0]           ls_wmask,
    output logic [31:0]          ls_rdata,
    output logic                 ls_ready,

    output logic [31:0]          mem_addr,
    output logic                 mem_valid,
    output logic                 mem_wen,
    output logic [31:0]          mem_wdata,
    output logic [3:0]           mem_wmask,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_ready,

    output logic [CNT_WIDTH-1:0] conflict_cnt,
    output logic                 err_timeout
);

    localparam int WD_WIDTH = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_WIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_LS = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                last_ls;
    logic                last_ls_next;
    logic                grant_if;
    logic                grant_ls;
    logic                waiting;
    logic                busy;
    logic [WD_WIDTH-1:0] wd;

    // last_ls resets to 1 so that IF wins the first tie after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            last_ls <= 1'b1;
        end else begin
            state   <= state_next;
            last_ls <= last_ls_next;
        end
    end

    always_comb begin
        state_next   = state;
        last_ls_next = last_ls;
        grant_if     = 1'b0;
        grant_ls     = 1'b0;
        case (state)
            IDLE: begin
                if (if_valid && ls_valid) begin
                    grant_if = last_ls;
                    grant_ls = !last_ls;
                end else begin
                    grant_if = if_valid;
                    grant_ls = ls_valid;
                end
            end
            BUSY_IF: grant_if = 1'b1;
            BUSY_LS: grant_ls = 1'b1;
            default: begin
                grant_if = 1'b0;
                grant_ls = 1'b0;
            end
        endcase
        if (grant_if || grant_ls) begin
            if (mem_ready) begin
                state_next   = IDLE;
                last_ls_next = grant_ls;
            end else begin
                state_next   = grant_if ? BUSY_IF : BUSY_LS;
            end
        end
    end

    // Outputs are forced to zero while reset is held, even with requesters active
    always_comb begin
        mem_valid = 1'b0;
        mem_addr  = 32'h0;
        mem_wen   = 1'b0;
        mem_wdata = 32'h0;
        mem_wmask = 4'h0;
        if_ready  = 1'b0;
        if_rdata  = 32'h0;
        ls_ready  = 1'b0;
        ls_rdata  = 32'h0;
        if (rst) begin
            if (grant_if) begin
                mem_valid = 1'b1;
                mem_addr  = if_addr;
                if_ready  = mem_ready;
                if (mem_ready) begin
                    if_rdata = mem_rdata;
                end
            end else if (grant_ls) begin
                mem_valid = 1'b1;
                mem_addr  = ls_addr;
                mem_wen   = ls_wen;
                mem_wdata = ls_wdata;
                mem_wmask = ls_wmask;
                ls_ready  = mem_ready;
                if (mem_ready) begin
                    ls_rdata = mem_rdata;
                end
            end
        end
    end

    assign waiting = (grant_if && ls_valid) || (grant_ls && if_valid);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_cnt <= '0;
        end else if (waiting) begin
            conflict_cnt <= conflict_cnt + CNT_WIDTH'(1);
        end
    end

    // Watchdog saturates at its limit; the grant itself is never aborted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd          <= '0;
            err_timeout <= 1'b0;
        end else if (!busy || mem_ready) begin
            wd          <= '0;
        end else if (wd == WD_LIMIT) begin
            err_timeout <= 1'b1;
        end else begin
            wd          <= wd + WD_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_ysyx_24110015_mem_arbiter.sv
// Bench for ysyx_24110015_mem_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_ysyx_24110015_mem_arbiter;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic [31:0] ls_addr;
    logic        ls_valid;
    logic        ls_wen;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_wmask;
    logic [31:0] ls_rdata;
    logic        ls_ready;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] conflict_cnt;
    logic        err_timeout;

    int assertCount;
    int failCount;

    // Model: owner 0=none 1=IF 2=LS; stuck counts busy cycles without mem_ready
    int          mOwner;
    bit          mLastLs;
    logic [31:0] mCnt;
    int          mStuck;
    bit          mErr;
    int          nOwner;
    bit          nLastLs;
    logic [31:0] nCnt;
    int          nStuck;
    bit          nErr;
    bit          mIfDone;
    bit          mLsDone;

    ysyx_24110015_mem_arbiter #(
        .TIMEOUT   (TIMEOUT),
        .CNT_WIDTH (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_addr      (if_addr),
        .if_valid     (if_valid),
        .if_rdata     (if_rdata),
        .if_ready     (if_ready),
        .ls_addr      (ls_addr),
        .ls_valid     (ls_valid),
        .ls_wen       (ls_wen),
        .ls_wdata     (ls_wdata),
        .ls_wmask     (ls_wmask),
        .ls_rdata     (ls_rdata),
        .ls_ready     (ls_ready),
        .mem_addr     (mem_addr),
        .mem_valid    (mem_valid),
        .mem_wen      (mem_wen),
        .mem_wdata    (mem_wdata),
        .mem_wmask    (mem_wmask),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .conflict_cnt (conflict_cnt),
        .err_timeout  (err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic ifv, input logic [31:0] ifa,
                                 input logic lsv, input logic [31:0] lsa, input logic wen,
                                 input logic [31:0] wdat, input logic [3:0] wmsk,
                                 input logic rdy, input logic [31:0] rdat);
        if_valid  = ifv;
        if_addr   = ifa;
        ls_valid  = lsv;
        ls_addr   = lsa;
        ls_wen    = wen;
        ls_wdata  = wdat;
        ls_wmask  = wmsk;
        mem_ready = rdy;
        mem_rdata = rdat;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        nextCycle();
        rst = 1'b0;
        idleInputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " mem_valid"}, mem_valid, 0);
        checkOutput({tag, " mem_addr"}, mem_addr, 0);
        checkOutput({tag, " mem_wen"}, mem_wen, 0);
        checkOutput({tag, " mem_wdata"}, mem_wdata, 0);
        checkOutput({tag, " mem_wmask"}, mem_wmask, 0);
        checkOutput({tag, " if_ready"}, if_ready, 0);
        checkOutput({tag, " if_rdata"}, if_rdata, 0);
        checkOutput({tag, " ls_ready"}, ls_ready, 0);
        checkOutput({tag, " ls_rdata"}, ls_rdata, 0);
        checkOutput({tag, " conflict_cnt"}, conflict_cnt, 0);
        checkOutput({tag, " err_timeout"}, err_timeout, 0);
    endtask

    // Reference model: evaluate at negedge, commit at posedge
    initial begin
        int served;
        bit fin;
        mOwner  = 0;
        mLastLs = 1'b1;
        mCnt    = 32'h0;
        mStuck  = 0;
        mErr    = 1'b0;
        mIfDone = 1'b0;
        mLsDone = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                checkAllZero("model rst");
                nOwner  = 0;
                nLastLs = 1'b1;
                nCnt    = 32'h0;
                nStuck  = 0;
                nErr    = 1'b0;
                mIfDone = 1'b0;
                mLsDone = 1'b0;
            end else begin
                served = mOwner;
                if (served == 0) begin
                    if (if_valid && ls_valid) served = mLastLs ? 1 : 2;
                    else if (if_valid)        served = 1;
                    else if (ls_valid)        served = 2;
                end
                fin = (served != 0) && mem_ready;
                checkOutput("model mem_valid", mem_valid, served != 0);
                if (served == 1) begin
                    checkOutput("model mem_addr", mem_addr, if_addr);
                    checkOutput("model mem_wen", mem_wen, 0);
                    checkOutput("model mem_wdata", mem_wdata, 0);
                    checkOutput("model mem_wmask", mem_wmask, 0);
                end else if (served == 2) begin
                    checkOutput("model mem_addr", mem_addr, ls_addr);
                    checkOutput("model mem_wen", mem_wen, ls_wen);
                    checkOutput("model mem_wdata", mem_wdata, ls_wdata);
                    checkOutput("model mem_wmask", mem_wmask, ls_wmask);
                end
                checkOutput("model if_ready", if_ready, fin && served == 1);
                checkOutput("model ls_ready", ls_ready, fin && served == 2);
                if (served == 1 && fin)  checkOutput("model if_rdata", if_rdata, mem_rdata);
                else if (served != 1)    checkOutput("model if_rdata idle", if_rdata, 0);
                if (served == 2 && fin)  checkOutput("model ls_rdata", ls_rdata, mem_rdata);
                else if (served != 2)    checkOutput("model ls_rdata idle", ls_rdata, 0);
                checkOutput("model conflict_cnt", conflict_cnt, mCnt);
                checkOutput("model err_timeout", err_timeout, mErr);
                nCnt    = mCnt + (((served == 1 && ls_valid) || (served == 2 && if_valid)) ? 32'd1 : 32'd0);
                nOwner  = fin ? 0 : served;
                nLastLs = fin ? (served == 2) : mLastLs;
                nStuck  = (mOwner != 0 && !mem_ready) ? mStuck + 1 : 0;
                nErr    = mErr || (nStuck >= TIMEOUT);
                mIfDone = fin && served == 1;
                mLsDone = fin && served == 2;
            end
            @(posedge clk);
            mOwner  = nOwner;
            mLastLs = nLastLs;
            mCnt    = nCnt;
            mStuck  = nStuck;
            mErr    = nErr;
        end
    end

    initial begin
        bit          ifPend;
        bit          lsPend;
        logic [31:0] ifA;
        logic [31:0] lsA;
        logic [31:0] lsD;
        logic        lsW;
        logic [3:0]  lsM;
        logic        rdy;
        int          stall;

        assertCount = 0;
        failCount   = 0;
        rst = 1'b0;
        idleInputs();
        @(negedge clk);
        checkAllZero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // IF-only read completing in its first cycle
        nextCycle();
        applyStimulus(1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        checkOutput("t1 if_ready", if_ready, 1);
        checkOutput("t1 if_rdata", if_rdata, 32'hDEAD_BEEF);
        checkOutput("t1 ls_ready", ls_ready, 0);
        checkOutput("t1 mem_addr", mem_addr, 32'h8000_0000);
        nextCycle();
        idleInputs();

        // Tie from reset: IF first, LS write waits and then appears unmodified
        resetDut();
        for (int c = 0; c < 4; c++) begin
            nextCycle();
            applyStimulus(1'b1, 32'h8000_0100, 1'b1, 32'h9000_0040, 1'b1, 32'h1234_5678,
                          4'b0011, c == 3, 32'hCAFE_0001);
            @(negedge clk);
            checkOutput("t2 mem_addr on IF", mem_addr, 32'h8000_0100);
            checkOutput("t2 mem_wen on IF", mem_wen, 0);
            checkOutput("t2 mem_wmask on IF", mem_wmask, 0);
            checkOutput("t2 mem_wdata on IF", mem_wdata, 0);
            checkOutput("t2 conflict_cnt", conflict_cnt, c);
            checkOutput("t2 if_ready", if_ready, c == 3);
            checkOutput("t2 ls_ready", ls_ready, 0);
        end
        checkOutput("t2 if_rdata", if_rdata, 32'hCAFE_0001);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h9000_0040, 1'b1, 32'h1234_5678, 4'b0011, 1'b1, 32'hCAFE_0002);
        @(negedge clk);
        checkOutput("t2 mem_addr on LS", mem_addr, 32'h9000_0040);
        checkOutput("t2 mem_wen on LS", mem_wen, 1);
        checkOutput("t2 mem_wdata on LS", mem_wdata, 32'h1234_5678);
        checkOutput("t2 mem_wmask on LS", mem_wmask, 4'b0011);
        checkOutput("t2 ls_ready", ls_ready, 1);
        checkOutput("t2 ls_rdata", ls_rdata, 32'hCAFE_0002);
        checkOutput("t2 conflict_cnt after IF", conflict_cnt, 4);
        nextCycle();
        idleInputs();
        @(negedge clk);
        checkOutput("t2 conflict_cnt final", conflict_cnt, 4);

        // Both continuously valid, mem_ready every 2nd cycle: grants alternate
        for (int t = 0; t < 16; t++) begin
            nextCycle();
            applyStimulus(1'b1, 32'h8000_1000, 1'b1, 32'h8000_2000, 1'b0, 32'h0, 4'h0,
                          (t % 2) == 1, 32'h5A5A_0000 + t);
            @(negedge clk);
            if ((t % 2) == 1) begin
                checkOutput("t3 if_ready", if_ready, ((t / 2) % 2) == 0);
                checkOutput("t3 ls_ready", ls_ready, ((t / 2) % 2) == 1);
                checkOutput("t3 mem_addr", mem_addr, (((t / 2) % 2) == 0) ? 32'h8000_1000 : 32'h8000_2000);
            end
        end
        nextCycle();
        idleInputs();
        @(negedge clk);
        checkOutput("t3 conflict_cnt", conflict_cnt, 20);

        // Stuck grant: error after TIMEOUT busy cycles, sticky through completion
        for (int c = 0; c < 18; c++) begin
            nextCycle();
            applyStimulus(1'b1, 32'h8000_3000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
            @(negedge clk);
            if (c == 16) checkOutput("t4 err before limit", err_timeout, 0);
            if (c == 17) checkOutput("t4 err after limit", err_timeout, 1);
        end
        nextCycle();
        applyStimulus(1'b1, 32'h8000_3000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 32'h0BAD_F00D);
        @(negedge clk);
        checkOutput("t4 if_ready", if_ready, 1);
        checkOutput("t4 if_rdata", if_rdata, 32'h0BAD_F00D);
        checkOutput("t4 err at completion", err_timeout, 1);
        nextCycle();
        idleInputs();
        @(negedge clk);
        checkOutput("t4 err sticky", err_timeout, 1);
        checkOutput("t4 mem_valid idle", mem_valid, 0);

        // Reset during BUSY_LS, then IF wins the next tie
        resetDut();
        @(negedge clk);
        checkOutput("t5 err cleared", err_timeout, 0);
        for (int c = 0; c < 2; c++) begin
            nextCycle();
            applyStimulus(1'b0, 32'h0, 1'b1, 32'h9000_0500, 1'b1, 32'hA5A5_A5A5, 4'hF, 1'b0, 32'h0);
            @(negedge clk);
            checkOutput("t5 mem_addr LS", mem_addr, 32'h9000_0500);
        end
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b1, 32'h8000_0500, 1'b1, 32'h9000_0500, 1'b1, 32'hA5A5_A5A5, 4'hF, 1'b1, 32'hFFFF_FFFF);
        #1;
        checkAllZero("t5 in reset");
        nextCycle();
        rst = 1'b1;
        applyStimulus(1'b1, 32'h8000_0500, 1'b1, 32'h9000_0500, 1'b1, 32'hA5A5_A5A5, 4'hF, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("t5 mem_valid", mem_valid, 1);
        checkOutput("t5 mem_addr IF wins", mem_addr, 32'h8000_0500);
        checkOutput("t5 mem_wen IF", mem_wen, 0);
        nextCycle();
        applyStimulus(1'b1, 32'h8000_0500, 1'b1, 32'h9000_0500, 1'b1, 32'hA5A5_A5A5, 4'hF, 1'b1, 32'h1111_2222);
        @(negedge clk);
        checkOutput("t5 if_ready", if_ready, 1);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h9000_0500, 1'b1, 32'hA5A5_A5A5, 4'hF, 1'b1, 32'h3333_4444);
        @(negedge clk);
        checkOutput("t5 ls_ready", ls_ready, 1);
        nextCycle();
        idleInputs();

        // Randomized traffic obeying the hold-until-ready protocol
        ifPend = 1'b0;
        lsPend = 1'b0;
        ifA    = 32'h0;
        lsA    = 32'h0;
        lsD    = 32'h0;
        lsW    = 1'b0;
        lsM    = 4'h0;
        stall  = 0;
        for (int i = 0; i < 3000; i++) begin
            nextCycle();
            if (mIfDone) ifPend = 1'b0;
            if (mLsDone) lsPend = 1'b0;
            if (!ifPend && $urandom_range(0, 2) == 0) begin
                ifPend = 1'b1;
                ifA    = $urandom;
            end
            if (!lsPend && $urandom_range(0, 2) == 0) begin
                lsPend = 1'b1;
                lsA    = $urandom;
                lsW    = 1'($urandom_range(0, 1));
                lsD    = $urandom;
                lsM    = 4'($urandom_range(0, 15));
            end
            if (stall == 0 && $urandom_range(0, 399) == 0) stall = 20;
            rdy = (stall > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (stall > 0) stall--;
            if ($urandom_range(0, 699) == 0) begin
                rst    = 1'b0;
                ifPend = 1'b0;
                lsPend = 1'b0;
            end else begin
                rst = 1'b1;
            end
            applyStimulus(ifPend, ifA, lsPend, lsA, lsW, lsD, lsM, rdy, $urandom);
        end

        nextCycle();
        rst = 1'b1;
        idleInputs();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
